rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised, registered N:1 data multiplexer with valid/ready handshakes on every input and on the output; successor to the fixed 32-bit 4:1 combinational mux. It operates in one of two modes:
- **Fixed-address mode:** legacy behaviour, `address` picks the source.
- **Round-robin mode:** an internal fair arbiter picks among valid inputs.

The selected word is captured into an output register. The block sits between multiple producers (register-file read ports, ALU/memory result paths) and a single downstream consumer.

## Interface
- `WIDTH`, 32, data width in bits (≥1).
- `NUM_IN`, 4, number of inputs (≥2).
- `SEL_W`, `$clog2(NUM_IN)`, width of `address` and `out_src` (derived, not overridden).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  NUM_IN*WIDTH  flattened inputs; input i at bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NUM_IN  per-input valid.
- `in_ready`  out  NUM_IN  per-input ready; at most one bit high per cycle.
- `mode`  in  1  0 = fixed address, 1 = round-robin.
- `address`  in  SEL_W  source select in fixed mode; ignored in round-robin mode.
- `out_data`  out  WIDTH  registered selected word.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_src`  out  SEL_W  index of the input that produced `out_data`.

## Operation
- Transfer on any port occurs when valid && ready are both high at a rising edge.
- `load = !out_valid || out_ready`: the output register can take a word this cycle.
- **Fixed mode:**
  - grant = `address` if `in_valid[address]`; otherwise no grant.
  - `address` ≥ NUM_IN (non-power-of-2 NUM_IN) never grants.
- **Round-robin mode:**
  - Search begins at pointer `ptr` and wraps modulo NUM_IN; the first valid input is granted.
  - On each accepted round-robin grant g, `ptr` ← (g+1) mod NUM_IN.
  - `ptr` holds when there is no grant, and holds in fixed mode.
- `in_ready[i] = load && (grant == i)`. Combinational from `in_valid`, `mode`, `address`, `out_valid`, `out_ready`.
- On accept: `out_data` ← selected word, `out_src` ← grant index, `out_valid` ← 1.
- On `out_ready` with no new grant: `out_valid` ← 0; `out_data` and `out_src` hold their stale values.
- **Simultaneous drain and load:** the new word replaces the old one in the same edge. Full throughput is 1 word/cycle.
- **Mode change:** takes effect on the next grant evaluation. `ptr` is not reset by a mode change.
- Inputs must hold `in_data` and `in_valid` stable until accepted. The block does not check this.

## Timing
- Latency: 1 cycle from input accept to `out_valid`.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0.
  - `in_ready`=0 while `rst_n`=0.
- Reset mid-operation: any held word is discarded; no partial transfer is reported.
- Output stall: `out_valid`=1 && `out_ready`=0 forces all `in_ready` low. Output values hold.

## Configuration
- `RR_MUX_PARITY_EN`:
  - **Defined:** adds output port `out_parity` (1 bit), registered alongside `out_data`. `out_parity` = even parity (XOR reduction) of the captured word; reset value 0.
  - **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `mux_pkg` holds:
  - mode constants `MUX_MODE_FIXED`=1'b0 and `MUX_MODE_RR`=1'b1;
  - the default `WIDTH`/`NUM_IN` localparams.
- Sub-module `rr_arbiter` (NUM_IN parameter):
  - inputs: request vector, `ptr`;
  - outputs: grant index, grant-valid.
  - It is purely combinational. `ptr` lives in `rr_mux_n`.

## Test plan
- **Fixed mode, legacy values:** in0..in3 = 35, 688, 193, 566, all valid, `out_ready`=1; `address` sequence 0, 1, 2, 3.
  - `out_data` = 35, 688, 193, 566 on consecutive cycles.
  - `out_src` = 0, 1, 2, 3.
  - Only `in_ready[address]` is high.
- **Round-robin fairness:** all four inputs held valid, `out_ready`=1, from reset.
  - Grants cycle 0, 1, 2, 3, 0, …, one per cycle.
  - Each input gets exactly 2 grants in 8 cycles.
- **Round-robin skip:** only inputs 1 and 3 valid (27 and 319), `ptr`=0.
  - Grants alternate 1, 3, 1, 3.
  - `out_data` alternates 27, 319.
- **Backpressure:** `out_ready`=0 for 3 cycles after the first load of 722.
  - `out_valid`=1 and `out_data`=722 are held.
  - `in_ready`=0 throughout.
  - On `out_ready`=1, the next word loads in the same edge.
- **Reset mid-stream:** assert `rst_n`=0 asynchronously between edges while `out_valid`=1.
  - `out_valid`, `out_data`, `out_src` go to 0 immediately; `in_ready`=0.
  - After release, the first round-robin grant starts at input 0.
- **Parity** (only with `RR_MUX_PARITY_EN`): capture 32'h0000_0007 → `out_parity`=1; capture 32'h0000_0003 → `out_parity`=0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the rr_mux_n multiplexer slice.
//   MUX_MODE_FIXED / MUX_MODE_RR : encodings of the 1-bit mode input.
//   MUX_DEFAULT_WIDTH / MUX_DEFAULT_NUM_IN : default data width and input count.
package mux_pkg;

    localparam logic MUX_MODE_FIXED     = 1'b0;
    localparam logic MUX_MODE_RR        = 1'b1;

    localparam int   MUX_DEFAULT_WIDTH  = 32;
    localparam int   MUX_DEFAULT_NUM_IN = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting at ptr,
// wrapping modulo NUM_IN, and returns the first requesting index.
//   req     in   NUM_IN  request vector
//   ptr     in   SEL_W   index where the search starts (always < NUM_IN)
//   gnt     out  SEL_W   granted index (0 when nothing requests)
//   gnt_vld out  1       at least one request present
module rr_arbiter #(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_vld
);

    localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_IN);

    logic [SEL_W:0] cand;
    logic           hit;

    // Walk offsets from the far end back towards ptr so the closest
    // requesting input is the last (winning) assignment.
    always_comb begin
        gnt  = '0;
        cand = '0;
        hit  = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(i);
            if (cand >= NUM_L) begin
                cand = cand - NUM_L;
            end
            hit = 1'b0;
            for (int j = 0; j < NUM_IN; j++) begin
                if (cand == (SEL_W+1)'(j)) begin
                    hit = req[j];
                end
            end
            if (hit) begin
                gnt = cand[SEL_W-1:0];
            end
        end
    end

    assign gnt_vld = |req;

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N:1 multiplexer with valid/ready on every input and on
// the output. Fixed mode picks the input named by address; round-robin mode
// uses rr_arbiter with a rotating pointer kept here.
//   clk, rst_n      clock / async active-low reset
//   in_data         NUM_IN*WIDTH flattened inputs, input i at [i*WIDTH +: WIDTH]
//   in_valid        per-input valid
//   in_ready        per-input ready (at most one high)
//   mode            0 fixed address, 1 round-robin
//   address         source select in fixed mode
//   out_data        registered selected word
//   out_valid       output register holds a word
//   out_ready       consumer accepts out_data
//   out_src         index of the input that produced out_data
//   out_parity      (RR_MUX_PARITY_EN only) XOR reduction of the captured word
// Build option: define RR_MUX_PARITY_EN to add the out_parity port.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH  = MUX_DEFAULT_WIDTH,
    parameter  int NUM_IN = MUX_DEFAULT_NUM_IN,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        address,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef RR_MUX_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [SEL_W-1:0]        out_src
);

    localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_IN);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] arb_gnt;
    logic             arb_vld;
    logic             fix_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] sel_word;
    logic [SEL_W:0]   ptr_nxt;

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld)
    );

    // Out-of-range address (non-power-of-2 NUM_IN) matches no input.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (address == SEL_W'(i)) begin
                fix_vld = in_valid[i];
            end
        end
    end

    assign grant     = (mode == MUX_MODE_FIXED) ? address : arb_gnt;
    assign grant_vld = (mode == MUX_MODE_FIXED) ? fix_vld : arb_vld;
    assign load      = !out_valid || out_ready;
    // rst_n gates the handshake so no input sees ready while in reset.
    assign accept    = rst_n && load && grant_vld;

    always_comb begin
        in_ready = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_word    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept;
            end
        end
    end

    always_comb begin
        ptr_nxt = {1'b0, grant} + 1'b1;
        if (ptr_nxt >= NUM_L) begin
            ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_word;
                out_src   <= grant;
                if (mode == MUX_MODE_RR) begin
                    ptr <= ptr_nxt[SEL_W-1:0];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (accept) begin
            out_parity <= ^sel_word;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed stimulus for rr_mux_n with a behavioural reference
// model checked every falling edge, plus literal expectations per scenario.
module tb_rr_mux_n;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic              clk;
    logic              rst_n;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic              mode;
    logic [SW-1:0]     address;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_src;
`ifdef RR_MUX_PARITY_EN
    logic              out_parity;
`endif

    int checks = 0;
    int errors = 0;

    rr_mux_n #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .address    (address),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef RR_MUX_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_src    (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data  = '0;
    int            m_src   = 0;
    int            m_ptr   = 0;
    logic          m_par   = 1'b0;

    // Grant chosen by the rules: fixed picks address if it is valid; round
    // robin scans from the pointer upward with wraparound. -1 means none.
    function automatic int exp_grant(input logic md, input logic [SW-1:0] adr,
                                     input logic [N-1:0] v, input int p);
        if (md == 1'b0) begin
            if (int'(adr) < N && v[adr]) return int'(adr);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int mdl_grant();
        if (!(!m_valid || out_ready)) return -1;
        return exp_grant(mode, address, in_valid, m_ptr);
    endfunction

    function automatic logic [W-1:0] word_of(input int g);
        return in_data[g*W +: W];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
            m_par   <= 1'b0;
        end else if (mdl_grant() >= 0) begin
            m_valid <= 1'b1;
            m_data  <= word_of(mdl_grant());
            m_src   <= mdl_grant();
            m_par   <= ^word_of(mdl_grant());
            if (mode) m_ptr <= (mdl_grant() + 1) % N;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        er = '0;
        if (rst_n && mdl_grant() >= 0) er[mdl_grant()] = 1'b1;
        check("mdl_in_ready",  64'(in_ready),  64'(er));
        check("mdl_out_valid", 64'(out_valid), 64'(m_valid));
        check("mdl_out_data",  64'(out_data),  64'(m_data));
        check("mdl_out_src",   64'(out_src),   64'(m_src));
`ifdef RR_MUX_PARITY_EN
        check("mdl_out_parity", 64'(out_parity), 64'(m_par));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic set_word(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    int legacy [4] = '{35, 688, 193, 566};
    int cnt [4];

    initial begin
        rst_n = 1'b1; mode = 1'b0; address = '0; in_valid = '0;
        out_ready = 1'b0; in_data = '0;
        #1;
        rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; mode = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_src",   64'(out_src),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        in_valid = '0; mode = 1'b0;
        #19 rst_n = 1'b1;

        // fixed mode with the legacy operands
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_word(i, W'(legacy[i]));
        for (int a = 0; a < 4; a++) begin
            mode = 1'b0; address = SW'(a); in_valid = '1; out_ready = 1'b1;
            #2;
            check("fix_in_ready", 64'(in_ready), 64'(1 << a));
            @(posedge clk); #1;
            check("fix_out_data", 64'(out_data), 64'(legacy[a]));
            check("fix_out_src",  64'(out_src),  64'(a));
        end

        // address on an idle input: no grant, output drains, stale data kept
        address = 2'd2; in_valid = 4'b0001;
        #2;
        check("nogrant_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("nogrant_out_valid", 64'(out_valid), 64'd0);
        check("nogrant_out_data",  64'(out_data),  64'd566);
        check("nogrant_out_src",   64'(out_src),   64'd3);

        // round-robin fairness from reset
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        mode = 1'b1; in_valid = '1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_in_ready", 64'(in_ready), 64'(1 << (c % 4)));
            @(posedge clk); #1;
            check("rr_out_src", 64'(out_src), 64'(c % 4));
            cnt[out_src]++;
        end
        for (int i = 0; i < 4; i++) check("rr_grant_count", 64'(cnt[i]), 64'd2);

        // round-robin skip over idle inputs
        set_word(1, 32'd27); set_word(3, 32'd319); in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("skip_out_src",  64'(out_src),  (k % 2) ? 64'd3 : 64'd1);
            check("skip_out_data", 64'(out_data), (k % 2) ? 64'd319 : 64'd27);
        end

        // backpressure after loading 722
        set_word(0, 32'd722); set_word(1, 32'd800); in_valid = 4'b0001; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_first_load", 64'(out_data), 64'd722);
        in_valid = 4'b0010; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data",  64'(out_data),  64'd722);
            @(posedge clk); #1;
        end
        check("bp_hold_data", 64'(out_data), 64'd722);
        out_ready = 1'b1;
        #2;
        check("bp_release_in_ready", 64'(in_ready), 64'b0010);
        @(posedge clk); #1;
        check("bp_release_data", 64'(out_data), 64'd800);
        check("bp_release_src",  64'(out_src),  64'd1);

        // asynchronous reset while a word is held
        in_valid = '1; mode = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data",  64'(out_data),  64'd0);
        check("mid_rst_out_src",   64'(out_src),   64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd0);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'b0001);
        @(posedge clk); #1;
        check("post_rst_src",  64'(out_src),  64'd0);
        check("post_rst_data", 64'(out_data), 64'd722);

`ifdef RR_MUX_PARITY_EN
        mode = 1'b0; address = 2'd0; in_valid = 4'b0001; set_word(0, 32'h0000_0007);
        @(posedge clk); #1;
        check("parity_odd", 64'(out_parity), 64'd1);
        set_word(0, 32'h0000_0003);
        @(posedge clk); #1;
        check("parity_even", 64'(out_parity), 64'd0);
`endif

        in_valid = '0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
